// File: rtl/uart_tx_if.sv
// uart_tx_if: producer-side handshake bundle of the parametrised UART transmitter.
//   baud_tick  - one-clk strobe, OVERSAMPLE pulses per serial bit
//   start      - request to send din
//   din        - DATA_BITS payload, captured only when start is accepted
//   o_tx_done  - one-clk pulse when a frame's last stop bit completes
//   o_tx_busy  - high while any frame is being serialised
//   o_tx_full  - holding register occupied; start ignored while high
//   o_tx       - serial line, idle high
// master: the producer (FIFO pop logic / bench); slave: the transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 baud_tick;
  logic                 start;
  logic [DATA_BITS-1:0] din;
  logic                 o_tx_done;
  logic                 o_tx_busy;
  logic                 o_tx_full;
  logic                 o_tx;

  modport master (
    output baud_tick, start, din,
    input  o_tx_done, o_tx_busy, o_tx_full, o_tx
  );

  modport slave (
    input  baud_tick, start, din,
    output o_tx_done, o_tx_busy, o_tx_full, o_tx
  );
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter, LSB first, optional parity,
// 1 or 2 stop bits, bit timing from a shared baud_tick strobe. A one-entry
// holding register lets the next word queue while a frame is in flight, so
// frames can go out back to back with no idle gap.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset (abandons any frame in flight)
//   bus    - uart_tx_if.slave: baud_tick/start/din in, o_tx*/o_tx out
module uart_tx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 2 || OVERSAMPLE > 64) begin : g_bad_oversample
    $error("uart_tx_param: OVERSAMPLE must be 2..64");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Even mode sends the XOR of the word, odd mode its inverse.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data);
    logic p;
    p = ^data;
    if (PARITY_MODE == 2) begin
      parity_bit = ~p;
    end else begin
      parity_bit = p;
    end
  endfunction

  state_t               state_r;
  logic [TICK_W-1:0]    tick_cnt_r;
  logic [IDX_W-1:0]     bit_idx_r;
  logic                 stop_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] hold_r;
  logic                 full_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 tx_r;

  logic                 bit_end_s;
  logic                 frame_end_s;
  logic [IDX_W-1:0]     next_idx_s;

  // A bit ends on the edge that samples its OVERSAMPLE-th tick.
  assign bit_end_s   = bus.baud_tick && (tick_cnt_r == TICK_LAST);
  assign frame_end_s = (state_r == S_STOP) && bit_end_s && (stop_cnt_r == STOP_LAST);
  assign next_idx_s  = bit_idx_r + IDX_W'(1);

  // Frame sequencer, tick counter, holding register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      tick_cnt_r <= '0;
      bit_idx_r  <= '0;
      stop_cnt_r <= 1'b0;
      shift_r    <= '0;
      hold_r     <= '0;
      full_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      tx_r       <= 1'b1;
    end else begin
      done_r <= 1'b0;

      // Queue a word while busy; the frame-end edge handles start itself.
      if (busy_r && !full_r && bus.start && !frame_end_s) begin
        hold_r <= bus.din;
        full_r <= 1'b1;
      end

      if ((state_r != S_IDLE) && bus.baud_tick) begin
        tick_cnt_r <= bit_end_s ? '0 : tick_cnt_r + TICK_W'(1);
      end

      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            shift_r    <= bus.din;
            state_r    <= S_START;
            tx_r       <= 1'b0;
            busy_r     <= 1'b1;
            tick_cnt_r <= '0;
          end
        end
        S_START: begin
          if (bit_end_s) begin
            state_r   <= S_DATA;
            bit_idx_r <= '0;
            tx_r      <= shift_r[0];
          end
        end
        S_DATA: begin
          if (bit_end_s) begin
            if (bit_idx_r == IDX_LAST) begin
              if (PARITY_MODE != 0) begin
                state_r <= S_PARITY;
                tx_r    <= parity_bit(shift_r);
              end else begin
                state_r    <= S_STOP;
                stop_cnt_r <= 1'b0;
                tx_r       <= 1'b1;
              end
            end else begin
              bit_idx_r <= next_idx_s;
              tx_r      <= shift_r[next_idx_s];
            end
          end
        end
        S_PARITY: begin
          if (bit_end_s) begin
            state_r    <= S_STOP;
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b1;
          end
        end
        S_STOP: begin
          if (frame_end_s) begin
            done_r <= 1'b1;
            if (full_r) begin
              // Queued word goes out immediately; a same-edge start refills the slot.
              shift_r <= hold_r;
              state_r <= S_START;
              tx_r    <= 1'b0;
              full_r  <= bus.start;
              if (bus.start) begin
                hold_r <= bus.din;
              end
            end else if (bus.start) begin
              shift_r <= bus.din;
              state_r <= S_START;
              tx_r    <= 1'b0;
            end else begin
              state_r <= S_IDLE;
              tx_r    <= 1'b1;
              busy_r  <= 1'b0;
            end
          end else if (bit_end_s) begin
            stop_cnt_r <= stop_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
          full_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_tx      = tx_r;
  assign bus.o_tx_busy = busy_r;
  assign bus.o_tx_full = full_r;
  assign bus.o_tx_done = done_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances (default 8N1, even parity,
// odd parity, 7 data bits with 2 stop bits) share clk, reset and baud_tick.
module tb_uart_tx_param;

  logic       clk;
  logic       reset;
  logic       baud_tick;
  logic [3:0] start_v;
  logic [8:0] din_v [4];
  logic [3:0] tx_o, busy_o, full_o, done_o;

  int  errors;
  int  checks;
  int  tick_ph;
  bit  tick_en;
  bit  tk;
  int  ticks;

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx_if #(.DATA_BITS(8)) if2 ();
  uart_tx_if #(.DATA_BITS(7)) if3 ();

  uart_tx_param u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  uart_tx_param #(.PARITY_MODE(1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  uart_tx_param #(.PARITY_MODE(2)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
  uart_tx_param #(.DATA_BITS(7), .STOP_BITS(2)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));

  assign if0.baud_tick = baud_tick;
  assign if1.baud_tick = baud_tick;
  assign if2.baud_tick = baud_tick;
  assign if3.baud_tick = baud_tick;
  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if3.start = start_v[3];
  assign if0.din = din_v[0][7:0];
  assign if1.din = din_v[1][7:0];
  assign if2.din = din_v[2][7:0];
  assign if3.din = din_v[3][6:0];
  assign tx_o   = {if3.o_tx, if2.o_tx, if1.o_tx, if0.o_tx};
  assign busy_o = {if3.o_tx_busy, if2.o_tx_busy, if1.o_tx_busy, if0.o_tx_busy};
  assign full_o = {if3.o_tx_full, if2.o_tx_full, if1.o_tx_full, if0.o_tx_full};
  assign done_o = {if3.o_tx_done, if2.o_tx_done, if1.o_tx_done, if0.o_tx_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         dut;
    logic [8:0] din;
    logic [31:0] frame;  // line bits in send order, bit 0 = start bit
    int         nbits;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock edge, sample 1 time unit later, then set baud_tick for the next edge
  // (one tick every 4 clocks while enabled).
  task automatic cycle();
    @(posedge clk);
    #1;
    if (tick_en) begin
      tick_ph = (tick_ph + 1) % 4;
      baud_tick = (tick_ph == 0);
    end else begin
      baud_tick = 1'b0;
    end
  endtask

  // Start a frame on DUT d and check the line, busy, full and done on every
  // clock against tick-indexed expectations. Optional extras (-1 = unused):
  // done1 = tick of an intermediate done pulse, q1/q2 = ticks at which a
  // further start is issued, freeze_tick = tick at which baud_tick stops for 200 clk.
  task automatic watch(input int d, input logic [8:0] din0, input logic [31:0] frame,
                       input int nbits, input int done1,
                       input int q1_tick, input logic [8:0] q1_din,
                       input int q2_tick, input logic [8:0] q2_din,
                       input int freeze_tick);
    int  total, cnt, frz, frz_cnt;
    bit  t, q1_sent, q2_sent, q1_now, full_exp;
    total = nbits * 16;
    cnt = 0; frz = 0; frz_cnt = 0;
    q1_sent = 1'b0; q2_sent = 1'b0; full_exp = 1'b0;
    start_v[d] = 1'b1;
    din_v[d] = din0;
    cycle();
    start_v[d] = 1'b0;
    din_v[d] = ~din0;
    chk($sformatf("d%0d accept tx", d), {31'd0, tx_o[d]}, 32'd0);
    chk($sformatf("d%0d accept busy", d), {31'd0, busy_o[d]}, 32'd1);
    for (int n = 0; n < total * 4 + 400 && cnt < total; n++) begin
      start_v[d] = 1'b0;
      q1_now = 1'b0;
      if (cnt == q1_tick && !q1_sent) begin
        start_v[d] = 1'b1; din_v[d] = q1_din; q1_sent = 1'b1; q1_now = 1'b1;
      end else if (cnt == q2_tick && !q2_sent) begin
        start_v[d] = 1'b1; din_v[d] = q2_din; q2_sent = 1'b1;
      end
      if (cnt == freeze_tick && frz == 0) begin
        tick_en = 1'b0; frz = 1;
      end
      if (frz == 1) begin
        frz_cnt++;
        if (frz_cnt == 200) begin
          tick_en = 1'b1; frz = 2;
        end
      end
      t = baud_tick;
      cycle();
      if (t) cnt++;
      if (q1_now) full_exp = 1'b1;
      if (t && cnt == done1) full_exp = 1'b0;
      chk($sformatf("d%0d tx t%0d", d, cnt), {31'd0, tx_o[d]},
          (cnt < total) ? {31'd0, frame[cnt / 16]} : 32'd1);
      chk($sformatf("d%0d done t%0d", d, cnt), {31'd0, done_o[d]},
          (t && (cnt == done1 || cnt == total)) ? 32'd1 : 32'd0);
      chk($sformatf("d%0d busy t%0d", d, cnt), {31'd0, busy_o[d]},
          (cnt < total) ? 32'd1 : 32'd0);
      chk($sformatf("d%0d full t%0d", d, cnt), {31'd0, full_o[d]}, {31'd0, full_exp});
    end
    chk($sformatf("d%0d frame ticks", d), cnt, total);
    start_v[d] = 1'b0;
    cycle();
    chk($sformatf("d%0d post done", d), {31'd0, done_o[d]}, 32'd0);
    chk($sformatf("d%0d post tx", d), {31'd0, tx_o[d]}, 32'd1);
    chk($sformatf("d%0d post busy", d), {31'd0, busy_o[d]}, 32'd0);
  endtask

  initial begin
    errors = 0; checks = 0; tick_ph = 0; tick_en = 1'b1;
    reset = 1'b1; baud_tick = 1'b0; start_v = 4'b0000;
    for (int i = 0; i < 4; i++) din_v[i] = 9'h000;

    vecs[0] = '{0, 9'h0A5, 32'h0000_034A, 10};
    vecs[1] = '{0, 9'h000, 32'h0000_0200, 10};
    vecs[2] = '{0, 9'h0FF, 32'h0000_03FE, 10};
    vecs[3] = '{1, 9'h007, 32'h0000_060E, 11};
    vecs[4] = '{1, 9'h000, 32'h0000_0400, 11};
    vecs[5] = '{2, 9'h007, 32'h0000_040E, 11};
    vecs[6] = '{2, 9'h000, 32'h0000_0600, 11};
    vecs[7] = '{3, 9'h055, 32'h0000_03AA, 10};
    vecs[8] = '{3, 9'h07F, 32'h0000_03FE, 10};

    // Reset state on every instance.
    for (int i = 0; i < 3; i++) cycle();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("d%0d rst tx", d), {31'd0, tx_o[d]}, 32'd1);
      chk($sformatf("d%0d rst busy", d), {31'd0, busy_o[d]}, 32'd0);
      chk($sformatf("d%0d rst full", d), {31'd0, full_o[d]}, 32'd0);
      chk($sformatf("d%0d rst done", d), {31'd0, done_o[d]}, 32'd0);
    end
    reset = 1'b0;
    cycle();

    // Reset at tick 70 of a frame with a word queued behind it.
    start_v[0] = 1'b1; din_v[0] = 9'h0A5;
    cycle();
    ticks = 0;
    din_v[0] = 9'h03C;
    tk = baud_tick;
    cycle();
    start_v[0] = 1'b0;
    if (tk) ticks++;
    chk("rst-mid full before", {31'd0, full_o[0]}, 32'd1);
    for (int n = 0; n < 1000 && ticks < 70; n++) begin
      tk = baud_tick;
      cycle();
      if (tk) ticks++;
    end
    chk("rst-mid reached tick", ticks, 32'd70);
    chk("rst-mid busy before", {31'd0, busy_o[0]}, 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst-mid tx", {31'd0, tx_o[0]}, 32'd1);
    chk("rst-mid busy", {31'd0, busy_o[0]}, 32'd0);
    chk("rst-mid full", {31'd0, full_o[0]}, 32'd0);
    chk("rst-mid done", {31'd0, done_o[0]}, 32'd0);
    for (int n = 0; n < 40; n++) begin
      cycle();
      chk($sformatf("rst-after done c%0d", n), {31'd0, done_o[0]}, 32'd0);
      chk($sformatf("rst-after tx c%0d", n), {31'd0, tx_o[0]}, 32'd1);
      chk($sformatf("rst-after busy c%0d", n), {31'd0, busy_o[0]}, 32'd0);
    end

    // Single frames from the vector table.
    for (int i = 0; i < 9; i++) begin
      watch(vecs[i].dut, vecs[i].din, vecs[i].frame, vecs[i].nbits,
            -1, -1, 9'h000, -1, 9'h000, -1);
    end

    // 0x11 then queued 0x22 back to back; the 0x33 at tick 50 must be dropped.
    watch(0, 9'h011, 32'h0009_1222, 20, 160, 40, 9'h022, 50, 9'h033, -1);

    // baud_tick frozen for 200 clk in the middle of the data bits.
    watch(0, 9'h0A5, 32'h0000_034A, 10, -1, -1, 9'h000, -1, 9'h000, 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised successor of the fixed 8N1 UART transmitter. Serialises DATA_BITS-wide words, LSB first, with configurable parity, stop-bit count and oversample factor, all driven from the shared baud_tick strobe. Adds a one-entry holding register so a following frame can be queued while one is in flight, giving back-to-back frames with no idle gap. Sits between the system-side producer (e.g. FIFO pop logic) and the TX pin.

Parameters:
DATA_BITS, 8, payload bits per frame; legal 5..9
OVERSAMPLE, 16, baud_tick pulses per serial bit; legal 2..64
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; legal 1..2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
baud_tick  in  1  one-clk strobe, OVERSAMPLE per bit period
start  in  1  request to send din, sampled every clk
din  in  DATA_BITS  payload, captured only when start is accepted
o_tx_done  out  1  one-clk pulse when a frame's last stop bit completes
o_tx_busy  out  1  high while any frame is being serialised
o_tx_full  out  1  holding register occupied; start is ignored while high
o_tx  out  1  serial line, registered, idle high

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset, including mid-frame: state IDLE, o_tx=1, o_tx_busy=0, o_tx_full=0, o_tx_done=0, all counters 0, holding register cleared. Takes effect at the reset edge; the in-flight frame is abandoned.
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY_MODE=0.
- Bit timing:
  - Tick counter width is $clog2(OVERSAMPLE). It counts baud_tick only, so the FSM is frozen while baud_tick stays low.
  - A bit ends at the edge where the OVERSAMPLE-th tick of that bit is sampled. At that edge the counter clears, the state/bit index advances and o_tx is loaded with the next bit's value.
  - Every bit therefore lasts exactly OVERSAMPLE ticks.
- Accept from IDLE: start=1 sampled at edge E loads the shift register with din. At E: state=START, o_tx=0, o_tx_busy=1. Zero-cycle latency from acceptance to the start bit on the line.
- DATA: bit index 0..DATA_BITS-1; o_tx=shift[index], LSB first.
- PARITY: even mode sends XOR of the captured data; odd mode sends its inverse.
- STOP: o_tx=1 for STOP_BITS*OVERSAMPLE ticks.
- Queueing:
  - start=1 while busy and o_tx_full=0: din goes into the holding register and o_tx_full=1 from the next cycle.
  - start while o_tx_full=1: dropped, din not captured, no other effect.
- End-of-stop edge:
  - o_tx_done=1 for exactly that one cycle.
  - If o_tx_full=1: the holding register moves to the shift register, state=START, o_tx=0, o_tx_busy stays 1, o_tx_full=0. If start=1 on that same edge, din is captured into the now-free holding register and o_tx_full stays 1.
  - Else if start=1: din loads directly into the shift register, state=START, o_tx=0, busy stays 1.
  - Else: state=IDLE, o_tx=1, o_tx_busy=0.
- Frame length in ticks: (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) * OVERSAMPLE.
- Illegal parameter values fail elaboration ($error in an initial/generate check).

Test Plan:
- Defaults, baud_tick every 4 clk, din=8'hA5, one start pulse -> o_tx bits 0,1,0,1,0,0,1,0,1,1, each 16 ticks; o_tx_done single pulse at tick 160; busy high exactly ticks 0..160.
- PARITY_MODE=1, din=8'h07 -> parity bit 1, frame 176 ticks. PARITY_MODE=2, same din -> parity bit 0.
- STOP_BITS=2, DATA_BITS=7, din=7'h55 -> 7 data bits 1,0,1,0,1,0,1, then o_tx high 32 ticks; done at tick 160.
- Send 8'h11, start with 8'h22 at tick 40 -> o_tx_full=1; second start bit begins on the same edge as the first done pulse; busy never drops; two done pulses. A third start at tick 50 is dropped; the line shows only 0x11 and 0x22.
- Reset asserted at tick 70 of a frame -> next edge o_tx=1, busy=0, full=0, no done pulse. A new start afterwards produces a correct full frame.
- baud_tick held low 200 clk mid-DATA -> o_tx and state unchanged. Resuming ticks completes the frame with exact bit widths.
